miso_fifo_drain_arbiter: RTL

//  Round-robin scheduler draining NUM_FIFOS router miso_fifo instances into one shared output lane.

---
 rtl/miso_fifo_drain_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/miso_fifo_drain_arbiter.sv
// Round-robin drain of NUM_FIFOS first-word-fall-through FIFOs into one registered
// valid/ready lane; each grant pops up to BURST_LEN words before rotating.
module miso_fifo_drain_arbiter #(
    parameter int NUM_FIFOS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int ID_WIDTH   = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_clear,
    input  logic                             i_en,
    input  logic [NUM_FIFOS-1:0]             i_fifo_empty,
    input  logic [NUM_FIFOS*DATA_WIDTH-1:0]  i_fifo_data,
    output logic [NUM_FIFOS-1:0]             o_fifo_pop,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [ID_WIDTH-1:0]              o_grant_id,
    output logic                             o_busy
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                                  state;
    logic [ID_WIDTH-1:0]                     rr_ptr;
    logic [CNT_W-1:0]                        burst_cnt;
    logic [NUM_FIFOS-1:0][DATA_WIDTH-1:0]    fifo_word;
    logic                                    arb_found;
    logic [ID_WIDTH-1:0]                     arb_id;
    logic                                    grant_empty;
    logic                                    pop_ok;
    logic                                    last_pop;
    logic                                    burst_exit;
    logic [ID_WIDTH-1:0]                     next_rr;

    assign fifo_word = i_fifo_data;

    // First non-empty FIFO at or after rr_ptr, wrapping around.
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (!arb_found && !i_fifo_empty[(int'(rr_ptr) + i) % NUM_FIFOS]) begin
                arb_found = 1'b1;
                arb_id    = ID_WIDTH'((int'(rr_ptr) + i) % NUM_FIFOS);
            end
        end
    end

    assign grant_empty = i_fifo_empty[o_grant_id];
    // A pop needs room in the output stage: empty now, or draining on this edge.
    assign pop_ok      = (state == BURST) && !i_clear && i_en && !grant_empty &&
                         (!o_valid || i_ready);
    assign last_pop    = (burst_cnt == CNT_W'(BURST_LEN - 1));
    assign burst_exit  = !i_en || (pop_ok && last_pop) || (grant_empty && !pop_ok);
    assign next_rr     = (o_grant_id == ID_WIDTH'(NUM_FIFOS - 1)) ? '0 : o_grant_id + 1'b1;
    assign o_busy      = (state == BURST) || o_valid;

    for (genvar k = 0; k < NUM_FIFOS; k++) begin : g_pop
        assign o_fifo_pop[k] = pop_ok && (o_grant_id == ID_WIDTH'(k));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_grant_id <= '0;
        end else if (i_clear) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            o_valid   <= 1'b0;
        end else begin
            if (pop_ok) begin
                o_data  <= fifo_word[o_grant_id];
                o_valid <= 1'b1;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (i_en && arb_found) begin
                        o_grant_id <= arb_id;
                        burst_cnt  <= '0;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (pop_ok)
                        burst_cnt <= burst_cnt + 1'b1;
                    if (burst_exit) begin
                        state  <= IDLE;
                        rr_ptr <= next_rr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
